// File: rtl/instr_defs_pkg.sv
// instr_defs_pkg: shared MIPS opcode/funct codes, decoded ID encoding and decoded-record type
package instr_defs_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_JR      = 6'h08;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic [3:0] {
        ID_NOP     = 4'd0,
        ID_ADD     = 4'd1,
        ID_SUB     = 4'd2,
        ID_ORI     = 4'd3,
        ID_LW      = 4'd4,
        ID_SW      = 4'd5,
        ID_BEQ     = 4'd6,
        ID_LUI     = 4'd7,
        ID_JAL     = 4'd8,
        ID_JR      = 4'd9,
        ID_ILLEGAL = 4'd15
    } instr_id_t;

    typedef struct packed {
        instr_id_t   id;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] target;
    } instr_rec_t;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational decode of one instruction word into a record
//   word : 32-bit machine-code word
//   pc   : address this word is tagged with
//   rec  : id, raw register fields, extended immediate, pc, branch/jump target
module instr_field_decode
    import instr_defs_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] pc,
    output instr_rec_t  rec
);
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] sext;
    logic [31:0] pc4;
    instr_id_t   id;

    assign op    = word[31:26];
    assign funct = word[5:0];
    assign imm16 = word[15:0];
    assign sext  = {{16{imm16[15]}}, imm16};
    assign pc4   = pc + 32'd4;

    // Only the all-zero word is NOP; any other op-0 word must match a known funct.
    assign id = (word == 32'h0)                           ? ID_NOP :
                (op == OP_SPECIAL && funct == FN_ADD)     ? ID_ADD :
                (op == OP_SPECIAL && funct == FN_SUB)     ? ID_SUB :
                (op == OP_SPECIAL && funct == FN_JR)      ? ID_JR  :
                (op == OP_ORI)                            ? ID_ORI :
                (op == OP_LW)                             ? ID_LW  :
                (op == OP_SW)                             ? ID_SW  :
                (op == OP_BEQ)                            ? ID_BEQ :
                (op == OP_LUI)                            ? ID_LUI :
                (op == OP_JAL)                            ? ID_JAL : ID_ILLEGAL;

    always_comb begin
        rec        = '0;
        rec.id     = id;
        rec.rs     = word[25:21];
        rec.rt     = word[20:16];
        rec.rd     = word[15:11];
        rec.pc     = pc;
        rec.imm    = (id == ID_ORI)                                   ? {16'h0, imm16} :
                     (id == ID_LW || id == ID_SW || id == ID_BEQ)     ? sext :
                     (id == ID_LUI)                                   ? {imm16, 16'h0} : 32'h0;
        rec.target = (id == ID_BEQ) ? pc4 + {sext[29:0], 2'b00} :
                     (id == ID_JAL) ? {pc4[31:28], word[25:0], 2'b00} : 32'h0;
    end
endmodule

// File: rtl/instr_disassemble.sv
// instr_disassemble: streaming MIPS decoder with running PC, registered output record and counters
//   clk, reset_n            : clock, async active-low reset
//   in_valid/in_ready/in_word : input word handshake
//   pc_load/pc_value        : overwrite running PC (low two bits forced to 0)
//   out_valid/out_ready     : output record handshake
//   out_id..out_illegal     : decoded record fields
//   word_cnt/illegal_cnt    : saturating accepted-word and illegal-word counters
module instr_disassemble
    import instr_defs_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    input  logic             pc_load,
    input  logic [31:0]      pc_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_id,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_imm,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);
    logic [31:0] pc;
    logic [31:0] tag_pc;
    logic        accept;
    instr_rec_t  dec;
    instr_rec_t  rec;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // A load in the accept cycle takes effect for the word being accepted.
    assign tag_pc   = pc_load ? {pc_value[31:2], 2'b00} : pc;

    instr_field_decode u_dec (
        .word (in_word),
        .pc   (tag_pc),
        .rec  (dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            rec         <= '0;
            pc          <= PC_RESET;
            word_cnt    <= '0;
            illegal_cnt <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            rec         <= dec;
            pc          <= tag_pc + 32'd4;
            word_cnt    <= word_cnt + {{(CNT_W-1){1'b0}}, ~&word_cnt};
            illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, (dec.id == ID_ILLEGAL) && ~&illegal_cnt};
        end else begin
            if (pc_load) pc <= tag_pc;
            if (out_ready) out_valid <= 1'b0;
        end
    end

    assign out_id      = rec.id;
    assign out_rs      = rec.rs;
    assign out_rt      = rec.rt;
    assign out_rd      = rec.rd;
    assign out_imm     = rec.imm;
    assign out_pc      = rec.pc;
    assign out_target  = rec.target;
    assign out_illegal = rec.id == ID_ILLEGAL;
endmodule

// File: doc/instr_disassemble.md
Name: instr_disassemble

Overview:
- Streaming MIPS machine-code decoder. It is the inverse of the assembler block: 32-bit hex instruction words go in, decoded instruction ID, register fields, extended immediate and branch/jump target come out.
- Sits between the instruction-ROM dump reader and the trace/compare logic used in CPU verification.
- Tracks a running PC and per-stream statistics.

Parameters:
- PC_RESET, 32'h0000_3000, PC tagged to the first accepted word after reset.
- CNT_W, 16, width of the saturating word and illegal counters.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  block can accept a word this cycle
- in_word  in  32  machine-code word
- pc_load  in  1  overwrite the running PC
- pc_value  in  32  value loaded by pc_load; bits [1:0] are ignored (forced 0)
- out_valid  out  1  decoded record valid
- out_ready  in  1  consumer accepts the record
- out_id  out  4  0 NOP, 1 ADD, 2 SUB, 3 ORI, 4 LW, 5 SW, 6 BEQ, 7 LUI, 8 JAL, 9 JR, 15 ILLEGAL
- out_rs, out_rt, out_rd  out  5 each  raw fields [25:21], [20:16], [15:11]
- out_imm  out  32  extended immediate (rules below)
- out_pc  out  32  PC of this word
- out_target  out  32  branch/jump target; 0 for all other instructions
- out_illegal  out  1  set when out_id == 15
- word_cnt, illegal_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (async, reset_n low): out_valid=0, all out_* = 0, pc=PC_RESET, both counters = 0. in_ready is 1 while reset_n is high and out_valid is 0.
- Handshake: in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - The record appears registered on the next edge, so latency is 1 cycle. Full throughput is 1 word/cycle.
  - out_* stay stable while out_valid && !out_ready.
  - out_valid clears when a record is consumed and nothing is accepted in the same cycle.
- Decode, by priority:
  - word == 0 gives NOP (zero word only).
  - op 0 with funct 0x20 ADD, 0x22 SUB, 0x08 JR.
  - op 0x0D ORI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x0F LUI, 0x03 JAL.
  - Anything else is ILLEGAL. This includes op 0 with a nonzero word and another funct.
  - Field checks (shamt, zero fields) are not performed.
- Immediate:
  - ORI: zero-extend imm16.
  - LW, SW, BEQ: sign-extend imm16.
  - LUI: {imm16, 16'h0}.
  - All others: 0.
- Target:
  - BEQ: pc + 4 + (sext(imm16) << 2), modulo 2^32.
  - JAL: {pc_plus4[31:28], word[25:0], 2'b00}.
  - All others: 0.
- PC:
  - Each accept tags the word with the current pc, then pc += 4 (wraps modulo 2^32).
  - pc_load without an accept: pc = pc_value & ~3.
  - pc_load together with an accept: pc_load wins for tagging. The word is tagged pc_value & ~3, and next pc = (pc_value & ~3) + 4.
  - pc_load while stalled (in_ready=0) only updates pc and never alters the held output record.
- Counters:
  - word_cnt increments on every accept.
  - illegal_cnt increments on accepts that decode to ILLEGAL.
  - Both saturate at all-ones (no wrap).
- Mid-operation reset: any held record is discarded immediately; no record appears after reset is released until a new accept.

Decomposition:
- Shared package instr_defs_pkg holds:
  - opcode/funct localparams;
  - the 4-bit ID encoding;
  - the decoded-record struct (id, rs, rt, rd, imm, pc, target);
  - PC_RESET_DEFAULT.
- One combinational sub-module, instr_field_decode: word + pc in, record minus the handshake out. It is reused by trace-compare logic.
- The top level holds the PC register, output register and counters.

Test Plan:
- After reset, send 0x3C011234 (LUI), then 0x34221234 (ORI) back-to-back with out_ready=1.
  - Records on consecutive cycles: LUI with imm 0x12340000, pc 0x3000; ORI with rs=1, rt=2, imm 0x00001234, pc 0x3004. word_cnt=2.
- Send 0x1000FFFF (BEQ $0,$0,-1) at pc 0x3000.
  - id 6, imm 0xFFFFFFFF, target 0x3000.
- Assert pc_load with pc_value 0x00003013 in the same cycle as an accept of 0x0C000C05 (JAL).
  - out_pc 0x3010, target 0x00003014; the next word is tagged 0x3014.
- Hold out_ready=0 for 3 cycles with in_valid high.
  - in_ready=0, out_* stable, no counter change. On release, the second word follows 1 cycle later.
- Send 0x00000000, 0x03E00008, 0xFC000000.
  - IDs NOP, JR (rs=31), ILLEGAL with out_illegal=1; illegal_cnt=1.
- Pulse reset_n low while out_valid=1 with CNT_W forced to 2 and counters saturated at 3.
  - Outputs and counters read 0 asynchronously; the first accept after release is tagged 0x3000.
